// File: rtl/data_memory_responder_pkg.sv
// Shared constants for the data-memory responder: funct3 width codes, FSM encoding and
// the access-size decode used by both the top level and the lane aligner.
package data_memory_responder_pkg;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StWait = 2'd1;
  localparam logic [1:0] StResp = 2'd2;

  typedef enum logic [1:0] {
    SzByte,
    SzHalf,
    SzWord
  } size_e;

  // Unknown codes, and unsigned widths on a store, fall back to a full word.
  function automatic size_e decode_size(logic [2:0] funct3, logic we);
    size_e sz;
    case (funct3)
      F3_B:    sz = SzByte;
      F3_H:    sz = SzHalf;
      F3_BU:   sz = we ? SzWord : SzByte;
      F3_HU:   sz = we ? SzWord : SzHalf;
      default: sz = SzWord;
    endcase
    return sz;
  endfunction

  function automatic logic decode_unsigned(logic [2:0] funct3, logic we);
    return !we && ((funct3 == F3_BU) || (funct3 == F3_HU));
  endfunction

endpackage

// File: rtl/data_memory_responder_if.sv
// Load/store port between the core (master) and the data-memory responder (slave):
// a valid/ready request channel and a valid/ready response channel.
interface data_memory_responder_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [2:0]  req_funct3;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;
  logic        rsp_err;

  modport master (
    output req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    input  req_ready, rsp_valid, rsp_rdata, rsp_err
  );

  modport slave (
    input  req_valid, req_we, req_funct3, req_addr, req_wdata, rsp_ready,
    output req_ready, rsp_valid, rsp_rdata, rsp_err
  );
endinterface

// File: rtl/data_memory_responder_lane_align.sv
// Combinational byte-lane steering: store byte enables and data replication, load lane
// shift with sign/zero extension. The offset given here is already naturally aligned.
module data_memory_responder_lane_align
  import data_memory_responder_pkg::*;
(
  input  size_e       size_i,
  input  logic        unsigned_i,
  input  logic [1:0]  offset_i,
  input  logic [31:0] wdata_i,
  input  logic [31:0] rword_i,
  output logic [3:0]  be_o,
  output logic [31:0] wdata_o,
  output logic [31:0] rdata_o
);

  logic [31:0] shifted;

  assign shifted = rword_i >> {offset_i, 3'b000};

  always_comb begin
    be_o    = 4'b0000;
    wdata_o = '0;
    rdata_o = '0;
    unique case (size_i)
      SzByte: begin
        be_o    = 4'b0001 << offset_i;
        wdata_o = {4{wdata_i[7:0]}};
        rdata_o = {{24{!unsigned_i && shifted[7]}}, shifted[7:0]};
      end
      SzHalf: begin
        be_o    = 4'b0011 << offset_i;
        wdata_o = {2{wdata_i[15:0]}};
        rdata_o = {{16{!unsigned_i && shifted[15]}}, shifted[15:0]};
      end
      default: begin
        be_o    = 4'b1111;
        wdata_o = wdata_i;
        rdata_o = rword_i;
      end
    endcase
  end

endmodule

// File: rtl/data_memory_responder.sv
// Data-memory responder: one load/store at a time against a word-organised RAM, with a
// configurable wait latency. Define DMEM_ERR_EN to flag misaligned/out-of-range accesses.
module data_memory_responder
  import data_memory_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 256,
  parameter int unsigned LATENCY     = 1
) (
  input logic                    clk,
  input logic                    reset,
  data_memory_responder_if.slave bus
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  localparam logic [3:0] CntInit = (LATENCY == 0) ? 4'd0 : 4'(LATENCY - 1);

  logic [1:0]  state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        we_q;
  logic [2:0]  funct3_q;
  logic [31:0] addr_q, wdata_q;
  logic [31:0] rdata_q, rdata_d;
  logic        err_q, err_d;
  logic [31:0] mem_q [DEPTH_WORDS];

  logic          accept, enter_resp, mem_we;
  logic          acc_we, acc_unsigned, acc_err;
  logic [2:0]    acc_funct3;
  logic [31:0]   acc_addr, acc_wdata;
  size_e         acc_size;
  logic [1:0]    acc_off;
  logic [AW-1:0] widx;
  logic [3:0]    be;
  logic [31:0]   st_data, ld_data;

  assign bus.req_ready = (state_q == StIdle) && !reset;
  assign accept        = bus.req_valid && bus.req_ready;
  assign enter_resp    = ((state_q == StIdle) && accept && (LATENCY == 0)) ||
                         ((state_q == StWait) && (cnt_q == 4'd0));

  // With zero latency IDLE goes straight to RESP, so the access must use the live request.
  always_comb begin
    if (state_q == StIdle) begin
      acc_we     = bus.req_we;
      acc_funct3 = bus.req_funct3;
      acc_addr   = bus.req_addr;
      acc_wdata  = bus.req_wdata;
    end else begin
      acc_we     = we_q;
      acc_funct3 = funct3_q;
      acc_addr   = addr_q;
      acc_wdata  = wdata_q;
    end
  end

  assign acc_size     = decode_size(acc_funct3, acc_we);
  assign acc_unsigned = decode_unsigned(acc_funct3, acc_we);
  assign widx         = acc_addr[AW+1:2];

  always_comb begin
    unique case (acc_size)
      SzByte:  acc_off = acc_addr[1:0];
      SzHalf:  acc_off = {acc_addr[1], 1'b0};
      default: acc_off = 2'b00;
    endcase
  end

`ifdef DMEM_ERR_EN
  logic misaligned, out_of_range;
  assign misaligned   = ((acc_size == SzHalf) && acc_addr[0]) ||
                        ((acc_size == SzWord) && (acc_addr[1:0] != 2'b00));
  assign out_of_range = acc_addr[31:2] >= 30'(DEPTH_WORDS);
  assign acc_err      = misaligned || out_of_range;
`else
  // Upper address bits are deliberately ignored so accesses wrap modulo the RAM size.
  logic unused_addr_hi;
  assign unused_addr_hi = ^acc_addr[31:AW+2];
  assign acc_err        = 1'b0;
`endif

  data_memory_responder_lane_align u_lane_align (
    .size_i     (acc_size),
    .unsigned_i (acc_unsigned),
    .offset_i   (acc_off),
    .wdata_i    (acc_wdata),
    .rword_i    (mem_q[widx]),
    .be_o       (be),
    .wdata_o    (st_data),
    .rdata_o    (ld_data)
  );

  assign mem_we = enter_resp && acc_we && !acc_err && !reset;

  always_ff @(posedge clk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (be[i]) mem_q[widx][8*i +: 8] <= st_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    if (enter_resp) begin
      rdata_d = (acc_we || acc_err) ? 32'h0 : ld_data;
      err_d   = acc_err;
    end
    case (state_q)
      StIdle: begin
        if (accept) begin
          if (LATENCY == 0) begin
            state_d = StResp;
          end else begin
            state_d = StWait;
            cnt_d   = CntInit;
          end
        end
      end
      StWait: begin
        if (cnt_q == 4'd0) state_d = StResp;
        else               cnt_d   = cnt_q - 4'd1;
      end
      StResp: begin
        if (bus.rsp_ready) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= StIdle;
      cnt_q    <= 4'd0;
      we_q     <= 1'b0;
      funct3_q <= F3_W;
      addr_q   <= '0;
      wdata_q  <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      rdata_q <= rdata_d;
      err_q   <= err_d;
      if (accept) begin
        we_q     <= bus.req_we;
        funct3_q <= bus.req_funct3;
        addr_q   <= bus.req_addr;
        wdata_q  <= bus.req_wdata;
      end
    end
  end

  assign bus.rsp_valid = (state_q == StResp);
  assign bus.rsp_rdata = rdata_q;
  assign bus.rsp_err   = err_q;

endmodule

// File: tb/tb_data_memory_responder.sv
// Bench for data_memory_responder: LATENCY=1 and LATENCY=3 instances checked against a
// byte-array reference model; honours DMEM_ERR_EN when the build defines it.
module tb_data_memory_responder;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;
  int lat_cfg [2] = '{1, 3};

  logic [1:0]  rst       = 2'b11;
  logic [1:0]  req_valid = 2'b00;
  logic [1:0]  req_we    = 2'b00;
  logic [1:0]  rsp_ready = 2'b00;
  logic [2:0]  req_funct3 [2];
  logic [31:0] req_addr [2];
  logic [31:0] req_wdata [2];

  data_memory_responder_if bus0 ();
  data_memory_responder_if bus1 ();

  assign bus0.req_valid  = req_valid[0];
  assign bus0.req_we     = req_we[0];
  assign bus0.req_funct3 = req_funct3[0];
  assign bus0.req_addr   = req_addr[0];
  assign bus0.req_wdata  = req_wdata[0];
  assign bus0.rsp_ready  = rsp_ready[0];
  assign bus1.req_valid  = req_valid[1];
  assign bus1.req_we     = req_we[1];
  assign bus1.req_funct3 = req_funct3[1];
  assign bus1.req_addr   = req_addr[1];
  assign bus1.req_wdata  = req_wdata[1];
  assign bus1.rsp_ready  = rsp_ready[1];

  wire [1:0]  req_ready = {bus1.req_ready, bus0.req_ready};
  wire [1:0]  rsp_valid = {bus1.rsp_valid, bus0.rsp_valid};
  wire [1:0]  rsp_err   = {bus1.rsp_err, bus0.rsp_err};
  wire [63:0] rsp_rdata = {bus1.rsp_rdata, bus0.rsp_rdata};

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(1)) u_dut_l1 (
    .clk   (clk),
    .reset (rst[0]),
    .bus   (bus0)
  );

  data_memory_responder #(.DEPTH_WORDS(256), .LATENCY(3)) u_dut_l3 (
    .clk   (clk),
    .reset (rst[1]),
    .bus   (bus1)
  );

  // Reference model: plain byte-addressed memory, 1024 bytes per instance.
  logic [7:0] mm [2][1024];

  function automatic void model_access(input int s, input logic we, input logic [2:0] f3,
                                       input logic [31:0] addr, input logic [31:0] wdata,
                                       output logic [31:0] rd, output logic er);
    int unsigned sz;
    bit          uns;
    logic [31:0] a;
    logic [31:0] val;
    sz  = 4;
    uns = 0;
    if (f3 == 3'd0) sz = 1;
    else if (f3 == 3'd1) sz = 2;
    else if (f3 == 3'd4 && !we) begin sz = 1; uns = 1; end
    else if (f3 == 3'd5 && !we) begin sz = 2; uns = 1; end
    rd = 32'h0;
    er = 1'b0;
`ifdef DMEM_ERR_EN
    if ((addr % sz) != 0 || addr >= 32'd1024) begin
      er = 1'b1;
      return;
    end
    a = addr;
`else
    a = (addr - (addr % sz)) % 32'd1024;
`endif
    if (we) begin
      for (int b = 0; b < int'(sz); b++) mm[s][a + b] = wdata[8*b +: 8];
    end else begin
      val = 32'h0;
      for (int b = 0; b < int'(sz); b++) val = val | (32'(mm[s][a + b]) << (8 * b));
      if (!uns && sz < 4 && val[8*sz-1]) val = val | (32'hFFFF_FFFF << (8 * sz));
      rd = val;
    end
  endfunction

  // Drives one request (called just after a negedge), checks response latency, holding under
  // back-pressure with a competing request, and a return to idle after the handshake.
  task automatic txn(input int s, input logic we, input logic [2:0] f3, input logic [31:0] addr,
                     input logic [31:0] wdata, input int hold,
                     output logic [31:0] rd, output logic er);
    int n;
    req_valid[s]  = 1'b1;
    req_we[s]     = we;
    req_funct3[s] = f3;
    req_addr[s]   = addr;
    req_wdata[s]  = wdata;
    n = 0;
    while (!req_ready[s] && n < 20) begin @(negedge clk); n++; end
    checks++;
    if (req_ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL accept_wait dut%0d: req_ready=%b, required 1", s, req_ready[s]);
    end
    @(posedge clk);
    @(negedge clk);
    req_valid[s] = 1'b0;
    n = 0;
    while (rsp_valid[s] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    checks++;
    if (rsp_valid[s] !== 1'b1 || n != lat_cfg[s]) begin
      errors++;
      $display("FAIL rsp_latency dut%0d: rsp_valid=%b after %0d cycles, required 1 after %0d",
               s, rsp_valid[s], n, lat_cfg[s]);
    end
    rd = rsp_rdata[32*s +: 32];
    er = rsp_err[s];
    for (int i = 0; i < hold; i++) begin
      req_valid[s]  = 1'b1;
      req_we[s]     = 1'($urandom);
      req_funct3[s] = 3'($urandom);
      req_addr[s]   = $urandom_range(0, 63);
      req_wdata[s]  = $urandom;
      checks++;
      if (req_ready[s] !== 1'b0 || rsp_valid[s] !== 1'b1 ||
          rsp_rdata[32*s +: 32] !== rd || rsp_err[s] !== er) begin
        errors++;
        $display("FAIL rsp_hold dut%0d: ready=%b valid=%b rdata=%h err=%b, required 0 1 %h %b",
                 s, req_ready[s], rsp_valid[s], rsp_rdata[32*s +: 32], rsp_err[s], rd, er);
      end
      @(negedge clk);
    end
    rsp_ready[s] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rsp_ready[s] = 1'b0;
    checks++;
    if (rsp_valid[s] !== 1'b0 || req_ready[s] !== 1'b1) begin
      errors++;
      $display("FAIL idle_after_handshake dut%0d: rsp_valid=%b req_ready=%b, required 0 1",
               s, rsp_valid[s], req_ready[s]);
    end
    req_valid[s] = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b0 || rsp_valid[s] !== 1'b0 || rsp_rdata[32*s +: 32] !== 32'h0 ||
          rsp_err[s] !== 1'b0) begin
        errors++;
        $display("FAIL reset_state dut%0d: ready=%b valid=%b rdata=%h err=%b, required 0 0 0 0",
                 s, req_ready[s], rsp_valid[s], rsp_rdata[32*s +: 32], rsp_err[s]);
      end
    end
    rst = 2'b00;
    #1;
    for (int s = 0; s < 2; s++) begin
      checks++;
      if (req_ready[s] !== 1'b1) begin
        errors++;
        $display("FAIL reset_release dut%0d: req_ready=%b, required 1", s, req_ready[s]);
      end
    end
    @(negedge clk);
  endtask

  task automatic test_preload();
    logic [31:0] rd, erd, w;
    logic        er, eer;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 16; i++) begin
        w = $urandom | 32'h0100_0001;
        model_access(s, 1'b1, 3'b010, 32'(4 * i), w, erd, eer);
        txn(s, 1'b1, 3'b010, 32'(4 * i), w, 0, rd, er);
        checks++;
        if (rd !== erd || er !== eer) begin
          errors++;
          $display("FAIL preload_store dut%0d word %0d: rdata=%h err=%b, required %h %b",
                   s, i, rd, er, erd, eer);
        end
      end
    end
  endtask

  task automatic test_word();
    logic [31:0] rd, erd;
    logic        er, eer;
    model_access(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, erd, eer);
    txn(0, 1'b1, 3'b010, 32'h10, 32'hDEADBEEF, 0, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b0) begin
      errors++;
      $display("FAIL sw_response: rdata=%h err=%b, required 00000000 0", rd, er);
    end
    model_access(0, 1'b0, 3'b010, 32'h10, 32'h0, erd, eer);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'hDEADBEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL lw_after_sw: rdata=%h err=%b, required deadbeef 0", rd, er);
    end
  endtask

  task automatic test_byte();
    logic [31:0] rd, erd, exp [3];
    logic [2:0]  f3s [3];
    logic [31:0] ads [3];
    logic        er, eer;
    exp = '{32'hFFFFFF80, 32'h00000080, 32'h80ADBEEF};
    f3s = '{3'b000, 3'b100, 3'b010};
    ads = '{32'h13, 32'h13, 32'h10};
    model_access(0, 1'b1, 3'b000, 32'h13, 32'hAAAA_AA80, erd, eer);
    txn(0, 1'b1, 3'b000, 32'h13, 32'hAAAA_AA80, 0, rd, er);
    for (int i = 0; i < 3; i++) begin
      model_access(0, 1'b0, f3s[i], ads[i], 32'h0, erd, eer);
      txn(0, 1'b0, f3s[i], ads[i], 32'h0, 0, rd, er);
      checks++;
      if (rd !== exp[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL byte_load %0d: rdata=%h err=%b, required %h 0", i, rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_half();
    logic [31:0] rd, erd, exp [3];
    logic [2:0]  f3s [3];
    logic [31:0] ads [3];
    logic        er, eer;
    exp = '{32'h1234BEEF, 32'h00001234, 32'h0000BEEF};
    f3s = '{3'b010, 3'b001, 3'b101};
    ads = '{32'h10, 32'h12, 32'h10};
    model_access(0, 1'b1, 3'b001, 32'h12, 32'h5555_1234, erd, eer);
    txn(0, 1'b1, 3'b001, 32'h12, 32'h5555_1234, 0, rd, er);
    for (int i = 0; i < 3; i++) begin
      model_access(0, 1'b0, f3s[i], ads[i], 32'h0, erd, eer);
      txn(0, 1'b0, f3s[i], ads[i], 32'h0, 0, rd, er);
      checks++;
      if (rd !== exp[i] || er !== 1'b0) begin
        errors++;
        $display("FAIL half_load %0d: rdata=%h err=%b, required %h 0", i, rd, er, exp[i]);
      end
    end
  endtask

  task automatic test_backpressure();
    logic [31:0] rd, erd;
    logic        er, eer;
    model_access(0, 1'b0, 3'b010, 32'h10, 32'h0, erd, eer);
    txn(0, 1'b0, 3'b010, 32'h10, 32'h0, 5, rd, er);
    checks++;
    if (rd !== 32'h1234BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL backpressure_load: rdata=%h err=%b, required 1234beef 0", rd, er);
    end
  endtask

  task automatic test_err_config();
    logic [31:0] rd, erd;
    logic        er, eer;
`ifdef DMEM_ERR_EN
    model_access(0, 1'b0, 3'b010, 32'h11, 32'h0, erd, eer);
    txn(0, 1'b0, 3'b010, 32'h11, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'h0 || er !== 1'b1) begin
      errors++;
      $display("FAIL misaligned_lw: rdata=%h err=%b, required 00000000 1", rd, er);
    end
    model_access(0, 1'b1, 3'b010, 32'h400, 32'h5, erd, eer);
    txn(0, 1'b1, 3'b010, 32'h400, 32'h5, 0, rd, er);
    checks++;
    if (er !== 1'b1) begin
      errors++;
      $display("FAIL out_of_range_sw: err=%b, required 1", er);
    end
`else
    model_access(0, 1'b0, 3'b010, 32'h11, 32'h0, erd, eer);
    txn(0, 1'b0, 3'b010, 32'h11, 32'h0, 0, rd, er);
    checks++;
    if (rd !== 32'h1234BEEF || er !== 1'b0) begin
      errors++;
      $display("FAIL forced_align_lw: rdata=%h err=%b, required 1234beef 0", rd, er);
    end
    model_access(0, 1'b1, 3'b010, 32'h400, 32'h5, erd, eer);
    txn(0, 1'b1, 3'b010, 32'h400, 32'h5, 0, rd, er);
`endif
    model_access(0, 1'b0, 3'b010, 32'h0, 32'h0, erd, eer);
    txn(0, 1'b0, 3'b010, 32'h0, 32'h0, 0, rd, er);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      errors++;
      $display("FAIL word0_after_sw_0x400: rdata=%h err=%b, required %h 0", rd, er, erd);
    end
  endtask

  task automatic test_reset_mid_txn();
    logic [31:0] rd, erd;
    logic        er, eer;
    int          n;
    req_valid[1] = 1'b1; req_we[1] = 1'b1; req_funct3[1] = 3'b010;
    req_addr[1]  = 32'h20; req_wdata[1] = 32'h77;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    rst[1] = 1'b1;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || req_ready[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_wait: rsp_valid=%b req_ready=%b, required 0 0",
               rsp_valid[1], req_ready[1]);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    #1;
    checks++;
    if (req_ready[1] !== 1'b1) begin
      errors++;
      $display("FAIL ready_after_reset: req_ready=%b, required 1", req_ready[1]);
    end
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      checks++;
      if (rsp_valid[1] !== 1'b0) begin
        errors++;
        $display("FAIL dropped_txn_response: rsp_valid=%b, required 0", rsp_valid[1]);
      end
    end
    model_access(1, 1'b0, 3'b010, 32'h20, 32'h0, erd, eer);
    txn(1, 1'b0, 3'b010, 32'h20, 32'h0, 0, rd, er);
    checks++;
    if (rd !== erd || er !== 1'b0) begin
      errors++;
      $display("FAIL store_dropped_by_reset: rdata=%h err=%b, required %h 0", rd, er, erd);
    end
    // Reset while a load response is pending discards it.
    req_valid[1] = 1'b1; req_we[1] = 1'b0; req_addr[1] = 32'h24;
    @(posedge clk);
    @(negedge clk);
    req_valid[1] = 1'b0;
    n = 0;
    while (rsp_valid[1] !== 1'b1 && n < 40) begin @(negedge clk); n++; end
    rst[1] = 1'b1;
    #1;
    checks++;
    if (rsp_valid[1] !== 1'b0 || rsp_rdata[63:32] !== 32'h0 || rsp_err[1] !== 1'b0) begin
      errors++;
      $display("FAIL reset_in_resp: valid=%b rdata=%h err=%b, required 0 00000000 0",
               rsp_valid[1], rsp_rdata[63:32], rsp_err[1]);
    end
    @(negedge clk);
    rst[1] = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_random();
    logic [31:0] rd, erd, addr, wd;
    logic [2:0]  f3;
    logic        er, eer, we;
    for (int s = 0; s < 2; s++) begin
      for (int i = 0; i < 30; i++) begin
        we   = 1'($urandom_range(0, 1));
        f3   = 3'($urandom_range(0, 7));
        addr = 32'($urandom_range(0, 63));
        if ($urandom_range(0, 3) == 0) addr = addr | ($urandom & 32'hFFFF_FC00);
        wd   = $urandom;
        model_access(s, we, f3, addr, wd, erd, eer);
        txn(s, we, f3, addr, wd, $urandom_range(0, 2), rd, er);
        checks++;
        if (rd !== erd || er !== eer) begin
          errors++;
          $display("FAIL random dut%0d we=%b f3=%0d addr=%h: rdata=%h err=%b, required %h %b",
                   s, we, f3, addr, rd, er, erd, eer);
        end
      end
    end
  endtask

  initial begin
    for (int s = 0; s < 2; s++) begin
      req_funct3[s] = 3'b010;
      req_addr[s]   = 32'h0;
      req_wdata[s]  = 32'h0;
    end
    test_reset();
    test_preload();
    test_word();
    test_byte();
    test_half();
    test_backpressure();
    test_err_config();
    test_reset_mid_txn();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
